// File: rtl/serdes_pkg.sv
// serdes_pkg: shared state type, counter-width helper and default word size for the serial link
package serdes_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int SERDES_WIDTH = 5;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serdes_out_reg.sv
// serdes_out_reg: WIDTH-bit valid/ready holding register with load, accept and overrun detection
module serdes_out_reg
    import serdes_pkg::*;
#(
    parameter int WIDTH = SERDES_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             ready,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    output logic             overrun
);

    // Load when empty or being drained this cycle; a load into a held word is dropped and flagged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_out   <= '0;
            par_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= load && par_valid && !ready;
            if (load && (!par_valid || ready)) begin
                par_out   <= word;
                par_valid <= 1'b1;
            end else if (ready) begin
                par_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_deserializer.sv
// serial_deserializer: collects sof-delimited serial frames into words with valid/ready output.
// Optional SERDES_PARITY_EN adds a trailing even-parity bit per frame and a parity_err pulse.
module serial_deserializer
    import serdes_pkg::*;
#(
    parameter int WIDTH     = SERDES_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_en,
    input  logic             sof,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
`ifdef SERDES_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CW = cnt_w(WIDTH);
`ifdef SERDES_PARITY_EN
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sh, sh_n, word;
    logic             load, ferr_n, perr_n;

    function automatic logic [WIDTH-1:0] fill(input logic [WIDTH-1:0] b, input logic bit_in);
        return (MSB_FIRST != 0) ? {b[WIDTH-2:0], bit_in} : {bit_in, b[WIDTH-1:1]};
    endfunction

    // State, counter, shift register and error pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            frame_err <= 1'b0;
`ifdef SERDES_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sh        <= sh_n;
            frame_err <= ferr_n;
`ifdef SERDES_PARITY_EN
            parity_err <= perr_n;
`endif
        end
    end

    // Next-state: sof always restarts a frame (aborting any partial one); completion hands off the word
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        load    = 1'b0;
        ferr_n  = 1'b0;
        perr_n  = 1'b0;
`ifdef SERDES_PARITY_EN
        word    = sh;
`else
        word    = fill(sh, ser_in);
`endif
        if (ser_en) begin
            if (sof) begin
                state_n = SHIFT;
                cnt_n   = CW'(1);
                sh_n    = fill('0, ser_in);
                ferr_n  = (state == SHIFT);
            end else if (state == SHIFT) begin
                if (cnt == LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
`ifdef SERDES_PARITY_EN
                    perr_n  = ^sh ^ ser_in;
                    load    = !perr_n;
`else
                    load    = 1'b1;
`endif
                end else begin
                    sh_n  = fill(sh, ser_in);
                    cnt_n = cnt + 1'b1;
                end
            end
        end
    end

    assign busy = (state == SHIFT);

    serdes_out_reg #(.WIDTH(WIDTH)) u_out (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .word     (word),
        .ready    (par_ready),
        .par_out  (par_out),
        .par_valid(par_valid),
        .overrun  (overrun)
    );

endmodule

// File: tb/tb_serial_deserializer.sv
// tb_serial_deserializer: directed self-checking bench for serial_deserializer (MSB- and LSB-first instances)
module tb_serial_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ser_in = 1'b0;
    logic       ser_en = 1'b0;
    logic       sof = 1'b0;
    logic       par_ready = 1'b0;
    logic [4:0] par_out, l_par_out;
    logic       par_valid, busy, frame_err, overrun;
    logic       l_par_valid, l_busy, l_frame_err, l_overrun;
`ifdef SERDES_PARITY_EN
    logic       parity_err, l_parity_err;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    serial_deserializer #(.WIDTH(5), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .ser_in(ser_in), .ser_en(ser_en), .sof(sof),
        .par_out(par_out), .par_valid(par_valid), .par_ready(par_ready),
        .busy(busy), .frame_err(frame_err), .overrun(overrun)
`ifdef SERDES_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    serial_deserializer #(.WIDTH(5), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .ser_in(ser_in), .ser_en(ser_en), .sof(sof),
        .par_out(l_par_out), .par_valid(l_par_valid), .par_ready(par_ready),
        .busy(l_busy), .frame_err(l_frame_err), .overrun(l_overrun)
`ifdef SERDES_PARITY_EN
        , .parity_err(l_parity_err)
`endif
    );

    task automatic step(input logic en, input logic b, input logic s);
        ser_en = en;
        ser_in = b;
        sof    = s;
        @(negedge clk);
        ser_en = 1'b0;
        ser_in = 1'b0;
        sof    = 1'b0;
    endtask

    task automatic send_frame(input logic [4:0] w, input logic set_rdy);
        for (int i = 4; i >= 0; i--) begin
`ifndef SERDES_PARITY_EN
            if (i == 0 && set_rdy) par_ready = 1'b1;
`endif
            step(1'b1, w[i], i == 4);
        end
`ifdef SERDES_PARITY_EN
        if (set_rdy) par_ready = 1'b1;
        step(1'b1, ^w, 1'b0);
`endif
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (par_out !== 5'b0) begin bad++; $display("FAIL reset_par_out got=%b want=00000", par_out); end
        total++; if (par_valid !== 1'b0) begin bad++; $display("FAIL reset_par_valid got=%b want=0", par_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", frame_err, overrun); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_msb_first();
        par_ready = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL msb_busy got=%b want=1", busy); end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
`ifdef SERDES_PARITY_EN
        step(1'b1, 1'b1, 1'b0);
`endif
        total++; if (par_valid !== 1'b1) begin bad++; $display("FAIL msb_valid got=%b want=1", par_valid); end
        total++; if (par_out !== 5'b10110) begin bad++; $display("FAIL msb_par_out got=%b want=10110", par_out); end
        total++; if (l_par_out !== 5'b01101) begin bad++; $display("FAIL lsb_par_out got=%b want=01101", l_par_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL msb_busy_done got=%b want=0", busy); end
        step(1'b0, 1'b0, 1'b0);
        total++; if (par_valid !== 1'b0) begin bad++; $display("FAIL msb_valid_drop got=%b want=0", par_valid); end
    endtask

    task automatic test_gaps();
        logic [4:0] w;
        int gap_bad;
        w = 5'b10110;
        gap_bad = 0;
        for (int i = 4; i >= 0; i--) begin
            step(1'b1, w[i], i == 4);
            if (i > 0) begin
                repeat (3) begin
                    step(1'b0, 1'b0, 1'b0);
                    if (l_busy !== 1'b1) gap_bad++;
                end
            end
        end
`ifdef SERDES_PARITY_EN
        repeat (3) begin
            step(1'b0, 1'b0, 1'b0);
            if (l_busy !== 1'b1) gap_bad++;
        end
        step(1'b1, 1'b1, 1'b0);
`endif
        total++; if (gap_bad != 0) begin bad++; $display("FAIL gap_busy got=%0d_cycles_not_busy want=0", gap_bad); end
        total++; if (l_par_out !== 5'b01101 || l_par_valid !== 1'b1) begin bad++; $display("FAIL gap_lsb got=%b/%b want=01101/1", l_par_out, l_par_valid); end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overrun();
        par_ready = 1'b0;
        send_frame(5'b00001, 1'b0);
        send_frame(5'b11111, 1'b0);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%b want=1", overrun); end
        total++; if (par_out !== 5'b00001 || par_valid !== 1'b1) begin bad++; $display("FAIL ovr_hold got=%b/%b want=00001/1", par_out, par_valid); end
        step(1'b0, 1'b0, 1'b0);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_once got=%b want=0", overrun); end
        par_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        total++; if (par_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain got=%b want=0", par_valid); end
    endtask

    task automatic test_resync();
        par_ready = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL resync_early got=%b want=0", frame_err); end
        step(1'b1, 1'b1, 1'b1);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL resync_pulse got=%b want=1", frame_err); end
        step(1'b1, 1'b0, 1'b0);
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL resync_once got=%b want=0", frame_err); end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
`ifdef SERDES_PARITY_EN
        step(1'b1, 1'b1, 1'b0);
`endif
        total++; if (par_out !== 5'b10101 || par_valid !== 1'b1) begin bad++; $display("FAIL resync_word got=%b/%b want=10101/1", par_out, par_valid); end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        par_ready = 1'b0;
        send_frame(5'b00011, 1'b0);
        total++; if (par_out !== 5'b00011 || par_valid !== 1'b1) begin bad++; $display("FAIL b2b_first got=%b/%b want=00011/1", par_out, par_valid); end
        send_frame(5'b11100, 1'b1);
        total++; if (par_out !== 5'b11100 || par_valid !== 1'b1) begin bad++; $display("FAIL b2b_load got=%b/%b want=11100/1", par_out, par_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b want=0", overrun); end
        step(1'b0, 1'b0, 1'b0);
        total++; if (par_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", par_valid); end
    endtask

    task automatic test_async_reset();
        par_ready = 1'b0;
        send_frame(5'b10110, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        total++; if (busy !== 1'b1 || par_valid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b/%b want=1/1", busy, par_valid); end
        #2 rst = 1'b1;
        #1;
        total++; if (par_valid !== 1'b0 || par_out !== 5'b0) begin bad++; $display("FAIL arst_out got=%b/%b want=00000/0", par_out, par_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b want=0", busy); end
        @(negedge clk);
        rst = 1'b0;
        par_ready = 1'b1;
        send_frame(5'b01011, 1'b0);
        total++; if (par_out !== 5'b01011 || par_valid !== 1'b1) begin bad++; $display("FAIL arst_after got=%b/%b want=01011/1", par_out, par_valid); end
        step(1'b0, 1'b0, 1'b0);
    endtask

`ifdef SERDES_PARITY_EN
    task automatic test_parity();
        logic [4:0] w;
        w = 5'b10110;
        par_ready = 1'b1;
        for (int i = 4; i >= 0; i--) step(1'b1, w[i], i == 4);
        step(1'b1, 1'b0, 1'b0);
        total++; if (parity_err !== 1'b1 || par_valid !== 1'b0) begin bad++; $display("FAIL par_bad got=%b/%b want=1/0", parity_err, par_valid); end
        for (int i = 4; i >= 0; i--) step(1'b1, w[i], i == 4);
        step(1'b1, 1'b1, 1'b0);
        total++; if (parity_err !== 1'b0 || par_out !== 5'b10110 || par_valid !== 1'b1) begin bad++; $display("FAIL par_good got=%b/%b/%b want=0/10110/1", parity_err, par_out, par_valid); end
        step(1'b0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_msb_first();
        test_gaps();
        test_overrun();
        test_resync();
        test_back_to_back();
        test_async_reset();
`ifdef SERDES_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
